// File: rtl/pc_seq.sv
// pc_seq: fetch/branch sequencer for the 3-bit Forth core.
// Holds the program counter, fetches opcode and jump-target bytes over a
// req/ack port, and issues the ALU start / flag load strobes. All outputs
// come straight from registers; strobes are computed one cycle early so
// they are high exactly during the EXEC cycle they belong to.
module pc_seq #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  input  logic            flag_in,
  output logic [4:0]      alu_op,
  output logic            alu_go,
  output logic            f_load,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_OP  = 3'd1,
    F_TGT = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ALU  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_JF   = 3'b011;
  localparam logic [2:0] OP_JNF  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  // Jump opcodes carry a second byte holding the target address.
  function automatic logic is_jump(input logic [2:0] op);
    return (op == OP_JMP) || (op == OP_JF) || (op == OP_JNF);
  endfunction

  // Opcodes 110 and 111 are reserved.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Target byte to PC width: zero-extends for wide PCs, truncates for narrow ones.
  function automatic logic [PC_W-1:0] byte_to_pc(input logic [7:0] b);
    return PC_W'(b);
  endfunction

  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [7:0]      ir_r, ir_s;
  logic [PC_W-1:0] tgt_r, tgt_s;
  logic [4:0]      alu_op_r, alu_op_s;
  logic            mem_req_r, alu_go_r, f_load_r, halted_r, illegal_r;
  logic            go_s, ill_s;

  // Next-state, datapath updates and early strobe decode.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    ir_s     = ir_r;
    tgt_s    = tgt_r;
    alu_op_s = alu_op_r;
    go_s     = 1'b0;
    ill_s    = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = F_OP;
      end
      F_OP: begin
        if (mem_ack) begin
          ir_s = mem_rdata;
          pc_s = pc_r + PC_W'(1'b1);
          if (is_jump(mem_rdata[7:5])) begin
            state_s = F_TGT;
          end else begin
            state_s = EXEC;
            go_s    = (mem_rdata[7:5] == OP_ALU);
            ill_s   = is_illegal(mem_rdata[7:5]);
          end
        end else begin
          state_s = F_OP;
        end
      end
      F_TGT: begin
        if (mem_ack) begin
          tgt_s   = byte_to_pc(mem_rdata);
          pc_s    = pc_r + PC_W'(1'b1);
          state_s = EXEC;
        end else begin
          state_s = F_TGT;
        end
      end
      EXEC: begin
        state_s = F_OP;
        case (ir_r[7:5])
          OP_NOP: pc_s = pc_r;
          OP_ALU: alu_op_s = ir_r[4:0];
          OP_JMP: pc_s = tgt_r;
          OP_JF: begin
            if (flag_in) pc_s = tgt_r;
            else         pc_s = pc_r;
          end
          OP_JNF: begin
            if (!flag_in) pc_s = tgt_r;
            else          pc_s = pc_r;
          end
          OP_HALT: state_s = HALT;
          default: pc_s = pc_r;
        endcase
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      ir_r      <= 8'h00;
      tgt_r     <= '0;
      alu_op_r  <= 5'd0;
      mem_req_r <= 1'b0;
      alu_go_r  <= 1'b0;
      f_load_r  <= 1'b0;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      ir_r      <= ir_s;
      tgt_r     <= tgt_s;
      alu_op_r  <= alu_op_s;
      mem_req_r <= (state_s == F_OP) || (state_s == F_TGT);
      alu_go_r  <= go_s;
      f_load_r  <= go_s;
      halted_r  <= (state_s == HALT);
      illegal_r <= ill_s;
    end
  end

  assign mem_addr = pc_r;
  assign mem_req  = mem_req_r;
  assign alu_op   = alu_op_r;
  assign alu_go   = alu_go_r;
  assign f_load   = f_load_r;
  assign halted   = halted_r;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: memory responder with programmable wait states, a
// one-bit F register model, a fetch-address scoreboard, a table of
// small programs and a few hand-written reset/halt/wrap sequences.
module tb_pc_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       flag_in;
  logic [4:0] alu_op;
  logic       alu_go, f_load, halted, illegal;

  logic [7:0] w_addr;
  logic       w_req, w_go, w_fl, w_halt, w_ill;
  logic [4:0] w_op;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int         wait_cfg = 0;
  logic       stale_ack = 1'b0;
  logic       sb_en = 1'b0;
  logic       flag_init = 1'b0;
  logic       alu_res = 1'b0;
  logic       f_reg = 1'b0;
  int         go_cnt = 0, fl_cnt = 0, ill_cnt = 0;
  int         wcnt = 0;
  logic       prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  assign flag_in = f_reg;

  pc_seq #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flag_in(flag_in),
    .alu_op(alu_op), .alu_go(alu_go), .f_load(f_load), .halted(halted),
    .illegal(illegal)
  );

  // Second instance starting near the top of memory, always-ready NOP memory.
  pc_seq #(.PC_W(8), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mem_addr(w_addr), .mem_req(w_req),
    .mem_ack(1'b1), .mem_rdata(8'h00), .flag_in(1'b0),
    .alu_op(w_op), .alu_go(w_go), .f_load(w_fl), .halted(w_halt),
    .illegal(w_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {mem_req, alu_go, f_load, halted, illegal, alu_op, mem_addr}, {10'b0, 8'h00});
  endtask

  // Memory responder, F register model, strobe counters and fetch scoreboard.
  always @(negedge clk) begin
    if (prev_rst && prev_req && !prev_ack)
      chk("hold_req_addr", {mem_req, mem_addr}, {1'b1, prev_addr});
    if (alu_go)  go_cnt++;
    if (f_load)  fl_cnt++;
    if (illegal) ill_cnt++;
    if (!rst_n)      f_reg = flag_init;
    else if (f_load) f_reg = alu_res;
    if (!mem_req)                   wcnt = 0;
    else if (!prev_req || prev_ack) wcnt = 0;
    else                            wcnt = wcnt + 1;
    mem_ack   = stale_ack || (mem_req && (wcnt >= wait_cfg));
    mem_rdata = mem_ack ? mem[mem_addr] : 8'hA0;
    if (mem_ack && mem_req && rst_n && sb_en) begin
      if (exp_q.size() > 0) begin
        chk("fetch_addr", mem_addr, exp_q.pop_front());
      end else begin
        total++;
        bad++;
        $display("FAIL extra_fetch: got addr=%0h expected no fetch", mem_addr);
      end
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_rst  = rst_n;
    prev_addr = mem_addr;
  end

  typedef struct {
    logic [47:0] prog;
    int          n;
    int          wt;
    logic        f0;
    logic        res;
    logic [47:0] ea;
    int          ne;
    int          go;
    int          ill;
    logic [4:0]  op;
  } vec_t;

  function automatic vec_t mk(input logic [47:0] prog, input int n, input int wt,
                              input logic f0, input logic res, input logic [47:0] ea,
                              input int ne, input int go, input int ill, input logic [4:0] op);
    vec_t v;
    v.prog = prog; v.n = n; v.wt = wt; v.f0 = f0; v.res = res;
    v.ea = ea; v.ne = ne; v.go = go; v.ill = ill; v.op = op;
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    logic [7:0] wa [3];
    int         nw;
    int         found;
    vecs[0] = mk(48'h00_00_00_00_A0_00, 5, 0, 1'b0, 1'b0, 48'h00_01_02_03_04_00, 5, 0, 0, 5'd0);
    vecs[1] = mk(48'h25_60_10_00_00_00, 3, 0, 1'b0, 1'b1, 48'h00_01_02_10_00_00, 4, 1, 0, 5'd5);
    vecs[2] = mk(48'h80_40_40_33_00_00, 4, 0, 1'b1, 1'b0, 48'h00_01_02_03_33_00, 5, 0, 0, 5'd0);
    vecs[3] = mk(48'h25_60_10_00_00_00, 3, 3, 1'b0, 1'b1, 48'h00_01_02_10_00_00, 4, 1, 0, 5'd5);
    vecs[4] = mk(48'h60_10_00_00_00_00, 3, 0, 1'b0, 1'b0, 48'h00_01_02_03_00_00, 4, 0, 0, 5'd0);
    vecs[5] = mk(48'h80_20_00_00_00_00, 2, 0, 1'b0, 1'b0, 48'h00_01_20_00_00_00, 3, 0, 0, 5'd0);
    vecs[6] = mk(48'hC0_E7_00_00_00_00, 3, 0, 1'b0, 1'b0, 48'h00_01_02_03_00_00, 4, 0, 2, 5'd0);
    vecs[7] = mk(48'h21_80_30_00_00_00, 3, 1, 1'b1, 1'b0, 48'h00_01_02_30_00_00, 4, 1, 0, 5'd1);

    // Boot: NOP memory, zero-wait; wrap instance runs alongside.
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_state("reset_state");
    chk("reset_pc_wrap", w_addr, 8'hFE);
    rst_n = 1'b1;
    #1;
    chk("boot_dead_cycle", {mem_req, mem_addr}, {1'b0, 8'h00});
    for (int i = 0; i < 3; i++) wa[i] = 8'h00;
    nw = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) chk("boot_first_fetch", {mem_req, mem_addr}, {1'b1, 8'h00});
      if (w_req && nw < 3) begin
        wa[nw] = w_addr;
        nw++;
      end
    end
    chk("wrap_count", nw, 3);
    chk("wrap_fetch0", wa[0], 8'hFE);
    chk("wrap_fetch1", wa[1], 8'hFF);
    chk("wrap_fetch2", wa[2], 8'h00);
    chk("boot_strobes", go_cnt + fl_cnt + ill_cnt, 0);

    // Table of programs: each ends by fetching a HALT (unwritten memory is 0xA0).
    for (int v = 0; v < 8; v++) begin
      rst_n = 1'b0;
      sb_en = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'hA0;
      for (int i = 0; i < vecs[v].n; i++) mem[i] = vecs[v].prog[47-8*i -: 8];
      wait_cfg  = vecs[v].wt;
      flag_init = vecs[v].f0;
      alu_res   = vecs[v].res;
      exp_q.delete();
      for (int i = 0; i < vecs[v].ne; i++) exp_q.push_back(vecs[v].ea[47-8*i -: 8]);
      tick();
      tick();
      chk_reset_state("vec_reset_state");
      go_cnt = 0; fl_cnt = 0; ill_cnt = 0;
      sb_en = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 400 && !halted; c++) tick();
      chk("vec_halted", halted, 1'b1);
      chk("vec_fetch_left", exp_q.size(), 0);
      chk("vec_alu_go_cnt", go_cnt, vecs[v].go);
      chk("vec_f_load_cnt", fl_cnt, vecs[v].go);
      chk("vec_illegal_cnt", ill_cnt, vecs[v].ill);
      chk("vec_alu_op", alu_op, vecs[v].op);
    end

    // HALT is sticky and keeps the memory port idle.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("halt_hold", {halted, mem_req}, 2'b10);
    end

    // Reset while waiting on the target fetch; ack still high through reset.
    rst_n = 1'b0;
    sb_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA0;
    mem[0] = 8'h40;
    mem[1] = 8'h05;
    wait_cfg = 3;
    flag_init = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      tick();
      if (mem_req && mem_addr == 8'h01) found = 1;
    end
    chk("tgt_wait_reached", found, 1);
    tick();
    rst_n = 1'b0;
    stale_ack = 1'b1;
    tick();
    tick();
    chk_reset_state("mid_fetch_reset");
    rst_n = 1'b1;
    #1;
    chk("stale_ack_idle", {mem_req, mem_addr, halted}, {1'b0, 8'h00, 1'b0});
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h05);
    sb_en = 1'b1;
    tick();
    chk("refetch_from_reset_pc", {mem_req, mem_addr}, {1'b1, 8'h00});
    stale_ack = 1'b0;
    for (int c = 0; c < 100 && !halted; c++) tick();
    chk("refetch_halted", halted, 1'b1);
    chk("refetch_fetch_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Fetch/branch sequencer for the 3-bit Forth core.
- Holds the program counter and fetches instruction bytes over a simple req/ack memory port.
- Issues one-cycle ALU-start and flag-load strobes. The flag-load strobe drives the F register's load enable, and its F_In comes from the ALU.
- Consumes the registered flag F (flag_in) to resolve conditional jumps.

Parameters:
- PC_W, 8, program counter / memory address width.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- mem_addr  output  PC_W  fetch address, equals pc while mem_req=1.
- mem_req  output  1  fetch request, held until mem_ack.
- mem_ack  input  1  read data valid this cycle; ignored when mem_req=0.
- mem_rdata  input  8  instruction byte: [7:5] opcode, [4:0] operand.
- flag_in  input  1  current F register value.
- alu_op  output  5  operand of last ALU instruction, registered.
- alu_go  output  1  one-cycle ALU start strobe.
- f_load  output  1  one-cycle flag load enable (drives F register F_F).
- halted  output  1  high in HALT state.
- illegal  output  1  one-cycle pulse on reserved opcode.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state<=IDLE, pc<=RESET_PC, ir<=0, tgt<=0, alu_op<=0.
  - All outputs low; mem_addr=RESET_PC.
  - Reset mid-fetch abandons the request; a late mem_ack is ignored.
- States: IDLE, F_OP, F_TGT, EXEC, HALT. mem_req=1 only in F_OP and F_TGT. mem_addr=pc always.
- IDLE: go to F_OP next cycle (one dead cycle after reset release).
- F_OP: wait for mem_ack. On ack: ir<=mem_rdata, pc<=pc+1. Opcode JMP/JF/JNF -> F_TGT, else -> EXEC.
- Zero-wait ack (ack in the first request cycle) is legal.
- F_TGT: on ack: tgt<=mem_rdata[PC_W-1:0] (zero-extended if PC_W>8), pc<=pc+1, -> EXEC.
- EXEC: exactly one cycle, then F_OP, except HALT.
  - 000 NOP: no effect.
  - 001 ALU: alu_go=1, f_load=1, alu_op<=ir[4:0]. The F register captures on the following negedge, so the new flag is valid at the next EXEC.
  - 010 JMP: pc<=tgt.
  - 011 JF: pc<=tgt if flag_in=1, else pc unchanged.
  - 100 JNF: pc<=tgt if flag_in=0.
  - 101 HALT: -> HALT.
  - 110/111: illegal=1, otherwise treated as NOP.
- flag_in is sampled only at the posedge ending EXEC.
- HALT: halted=1, mem_req=0; remains until reset.
- pc increments modulo 2^PC_W (0xFF+1 -> 0x00 for PC_W=8). Target fetch at 0xFF wraps the next opcode fetch to 0x00.
- Cycle count with zero-wait memory:
  - NOP/ALU: 2 cycles per instruction (F_OP, EXEC).
  - Jumps: 3 cycles (F_OP, F_TGT, EXEC).
  - Each ack wait cycle adds 1.
- f_load is never asserted outside ALU EXEC, so the flag is preserved across jumps and NOPs.

Test Plan:
- Reset/boot: rst_n low 2 cycles, then high; mem_ack tied 1, memory NOPs -> mem_req=0 first cycle after release; mem_addr sequence 0,1,2,...; all strobes 0.
- ALU + JF taken: mem[0]=0x25 (ALU, op 5), mem[1]=0x60, mem[2]=0x10; flag_in driven 1 after f_load -> alu_go/f_load pulse once, alu_op=5; next opcode fetch at 0x10.
- JNF not taken vs JMP: flag_in=1, mem[0]=0x80, mem[1]=0x40, mem[2]=0x40, mem[3]=0x33 -> fetches 0x02, 0x03, then 0x33; f_load stays 0 throughout.
- Wait states: mem_ack delayed 3 cycles on each fetch -> mem_req and mem_addr held stable during waits; ir/tgt captured only on the ack cycle.
- Wrap: RESET_PC=0xFE, mem[0xFE]=0x00, mem[0xFF]=0x00 -> third opcode fetch at 0x00.
- Halt/illegal/reset: opcode 0xC0 -> illegal pulse, continues. Opcode 0xA0 -> halted=1, mem_req=0 for 10 cycles. Then reset asserted during an F_TGT wait -> IDLE, pc=RESET_PC, stale ack ignored.
